// File: rtl/meu_pkg.sv
// rtl/meu_pkg.sv - shared types for the memory-unit writeback arbiter
package meu_pkg;

    typedef struct packed {
        logic        wr;
        logic [5:0]  dest;
        logic [31:0] data;
        logic [4:0]  rob;
    } wb_entry_t;

    typedef enum logic {
        SRC_LQ = 1'b0,
        SRC_MS = 1'b1
    } src_e;

endpackage

// File: rtl/mem_wb_arbiter_if.sv
// rtl/mem_wb_arbiter_if.sv - producer inputs and writeback/completion outputs of the arbiter
interface mem_wb_arbiter_if;
    logic        flush_i;
    logic        lq_vld_i;
    logic        lq_wr_i;
    logic [5:0]  lq_dest_i;
    logic [31:0] lq_data_i;
    logic [4:0]  lq_rob_i;
    logic        lq_rdy_o;
    logic        ms_vld_i;
    logic        ms_wr_i;
    logic [5:0]  ms_dest_i;
    logic [31:0] ms_data_i;
    logic [4:0]  ms_rob_i;
    logic        ms_rdy_o;
    logic        wb_we_o;
    logic [5:0]  wb_dest_o;
    logic [31:0] wb_data_o;
    logic        cmp_vld_o;
    logic [4:0]  cmp_rob_o;
    logic [15:0] conflict_cnt_o;

    modport slave (
        input  flush_i,
        input  lq_vld_i, lq_wr_i, lq_dest_i, lq_data_i, lq_rob_i,
        input  ms_vld_i, ms_wr_i, ms_dest_i, ms_data_i, ms_rob_i,
        output lq_rdy_o, ms_rdy_o,
        output wb_we_o, wb_dest_o, wb_data_o, cmp_vld_o, cmp_rob_o, conflict_cnt_o
    );

    modport master (
        output flush_i,
        output lq_vld_i, lq_wr_i, lq_dest_i, lq_data_i, lq_rob_i,
        output ms_vld_i, ms_wr_i, ms_dest_i, ms_data_i, ms_rob_i,
        input  lq_rdy_o, ms_rdy_o,
        input  wb_we_o, wb_dest_o, wb_data_o, cmp_vld_o, cmp_rob_o, conflict_cnt_o
    );
endinterface

// File: rtl/wb_skid_fifo.sv
// rtl/wb_skid_fifo.sv - small per-source skid FIFO holding results that lost arbitration
module wb_skid_fifo
    import meu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  wb_entry_t                  push_data_i,
    input  logic                       pop_i,
    output wb_entry_t                  head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t         mem_q [DEPTH];
    wb_entry_t         mem_d [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) begin
                mem_d[wptr_q] = push_data_i;
                wptr_d        = wptr_q + 1'b1;
            end
            if (pop_i) begin
                rptr_d = rptr_q + 1'b1;
            end
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q   <= mem_d;
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/mem_wb_arbiter.sv
// rtl/mem_wb_arbiter.sv - round-robin arbiter for the shared PRF write / completion port
module mem_wb_arbiter
    import meu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             cpu_clk_i,
    input  logic             cpu_rst_i,
    mem_wb_arbiter_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t   lq_in, ms_in, lq_head, ms_head, lq_sel, ms_sel;
    logic [CW-1:0] lq_count, ms_count;
    logic        lq_full, ms_full, lq_empty, ms_empty;
    logic        kill, lq_acc, ms_acc, lq_cand, ms_cand;
    logic        gnt_lq, gnt_ms, lq_push, ms_push, lq_pop, ms_pop;

    src_e        last_grant_q, last_grant_d;
    logic        cmp_vld_q, cmp_vld_d, wb_we_q, wb_we_d;
    logic [5:0]  dest_q, dest_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  rob_q, rob_d;
    logic [15:0] cnt_q, cnt_d;

    assign lq_in = {bus.lq_wr_i, bus.lq_dest_i, bus.lq_data_i, bus.lq_rob_i};
    assign ms_in = {bus.ms_wr_i, bus.ms_dest_i, bus.ms_data_i, bus.ms_rob_i};

    assign kill    = bus.flush_i | cpu_rst_i;
    assign lq_acc  = bus.lq_vld_i & ~lq_full & ~kill;
    assign ms_acc  = bus.ms_vld_i & ~ms_full & ~kill;
    // A queued head always beats the incoming transfer so per-source order holds.
    assign lq_cand = ~lq_empty | lq_acc;
    assign ms_cand = ~ms_empty | ms_acc;
    assign lq_sel  = lq_empty ? lq_in : lq_head;
    assign ms_sel  = ms_empty ? ms_in : ms_head;

    always_comb begin
        gnt_lq = 1'b0;
        gnt_ms = 1'b0;
        if (!kill) begin
            if (lq_cand && ms_cand) begin
                gnt_lq = (last_grant_q == SRC_MS);
                gnt_ms = (last_grant_q == SRC_LQ);
            end else begin
                gnt_lq = lq_cand;
                gnt_ms = ms_cand;
            end
        end
    end

    assign lq_pop  = gnt_lq & ~lq_empty;
    assign ms_pop  = gnt_ms & ~ms_empty;
    assign lq_push = lq_acc & ~(gnt_lq & lq_empty);
    assign ms_push = ms_acc & ~(gnt_ms & ms_empty);

    wb_skid_fifo #(.DEPTH(DEPTH)) u_lq_fifo (
        .clk_i(cpu_clk_i), .clr_i(kill), .push_i(lq_push), .push_data_i(lq_in),
        .pop_i(lq_pop), .head_o(lq_head), .count_o(lq_count), .full_o(lq_full),
        .empty_o(lq_empty)
    );

    wb_skid_fifo #(.DEPTH(DEPTH)) u_ms_fifo (
        .clk_i(cpu_clk_i), .clr_i(kill), .push_i(ms_push), .push_data_i(ms_in),
        .pop_i(ms_pop), .head_o(ms_head), .count_o(ms_count), .full_o(ms_full),
        .empty_o(ms_empty)
    );

    always_comb begin
        last_grant_d = last_grant_q;
        cmp_vld_d    = 1'b0;
        wb_we_d      = 1'b0;
        dest_d       = dest_q;
        data_d       = data_q;
        rob_d        = rob_q;
        cnt_d        = cnt_q;
        if (gnt_lq) begin
            last_grant_d = SRC_LQ;
            cmp_vld_d    = 1'b1;
            wb_we_d      = lq_sel.wr;
            dest_d       = lq_sel.dest;
            data_d       = lq_sel.data;
            rob_d        = lq_sel.rob;
        end else if (gnt_ms) begin
            last_grant_d = SRC_MS;
            cmp_vld_d    = 1'b1;
            wb_we_d      = ms_sel.wr;
            dest_d       = ms_sel.dest;
            data_d       = ms_sel.data;
            rob_d        = ms_sel.rob;
        end
        if (lq_cand && ms_cand && !bus.flush_i && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            last_grant_q <= SRC_MS;
            cmp_vld_q    <= 1'b0;
            wb_we_q      <= 1'b0;
            dest_q       <= '0;
            data_q       <= '0;
            rob_q        <= '0;
            cnt_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            cmp_vld_q    <= cmp_vld_d;
            wb_we_q      <= wb_we_d;
            dest_q       <= dest_d;
            data_q       <= data_d;
            rob_q        <= rob_d;
            cnt_q        <= cnt_d;
        end
    end

    assert property (@(posedge cpu_clk_i) (lq_count <= CW'(DEPTH)) && (ms_count <= CW'(DEPTH)));

    assign bus.lq_rdy_o       = ~lq_full;
    assign bus.ms_rdy_o       = ~ms_full;
    assign bus.cmp_vld_o      = cmp_vld_q;
    assign bus.wb_we_o        = wb_we_q;
    assign bus.wb_dest_o      = dest_q;
    assign bus.wb_data_o      = data_q;
    assign bus.cmp_rob_o      = rob_q;
    assign bus.conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_wb_arbiter.sv
// tb/tb_mem_wb_arbiter.sv - self-checking bench for mem_wb_arbiter
module tb_mem_wb_arbiter;
    import meu_pkg::*;

    typedef struct {
        logic      lv;
        wb_entry_t le;
        logic      mv;
        wb_entry_t me;
        logic      fl;
        logic      e_cmp;
        logic      e_we;
        wb_entry_t e_out;
        logic      e_lrdy;
        logic      e_mrdy;
        logic [15:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_wb_arbiter_if bus();

    mem_wb_arbiter #(.DEPTH(2)) dut (
        .cpu_clk_i(clk),
        .cpu_rst_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic wb_entry_t ent(logic wr, logic [5:0] d, logic [31:0] dat, logic [4:0] r);
        wb_entry_t e;
        e.wr = wr; e.dest = d; e.data = dat; e.rob = r;
        return e;
    endfunction

    function automatic wb_entry_t lqe(int r);
        return ent(1'b1, 6'(r), 32'hA000_0000 + 32'(r), 5'(r));
    endfunction

    function automatic wb_entry_t mse(int r);
        return ent(1'b1, 6'(r + 32), 32'hB000_0000 + 32'(r), 5'(r));
    endfunction

    function automatic vec_t mk(logic lv, wb_entry_t le, logic mv, wb_entry_t me, logic fl,
                                logic ecmp, logic ewe, wb_entry_t eo, logic elr, logic emr,
                                logic [15:0] ecnt);
        vec_t v;
        v.lv = lv; v.le = le; v.mv = mv; v.me = me; v.fl = fl;
        v.e_cmp = ecmp; v.e_we = ewe; v.e_out = eo;
        v.e_lrdy = elr; v.e_mrdy = emr; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic lv, input wb_entry_t le, input logic mv,
                         input wb_entry_t me, input logic fl);
        bus.lq_vld_i  = lv;
        bus.lq_wr_i   = le.wr;
        bus.lq_dest_i = le.dest;
        bus.lq_data_i = le.data;
        bus.lq_rob_i  = le.rob;
        bus.ms_vld_i  = mv;
        bus.ms_wr_i   = me.wr;
        bus.ms_dest_i = me.dest;
        bus.ms_data_i = me.data;
        bus.ms_rob_i  = me.rob;
        bus.flush_i   = fl;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic ecmp, input logic ewe,
                           input wb_entry_t eo, input logic elr, input logic emr,
                           input logic [15:0] ecnt);
        chk({tag, " cmp_vld"}, 32'(bus.cmp_vld_o), 32'(ecmp));
        chk({tag, " wb_we"},   32'(bus.wb_we_o),   32'(ewe));
        chk({tag, " dest"},    32'(bus.wb_dest_o), 32'(eo.dest));
        chk({tag, " data"},    bus.wb_data_o,      eo.data);
        chk({tag, " rob"},     32'(bus.cmp_rob_o), 32'(eo.rob));
        chk({tag, " lq_rdy"},  32'(bus.lq_rdy_o),  32'(elr));
        chk({tag, " ms_rdy"},  32'(bus.ms_rdy_o),  32'(emr));
        chk({tag, " cnt"},     32'(bus.conflict_cnt_o), 32'(ecnt));
    endtask

    vec_t vecs[$];

    initial begin
        wb_entry_t z, t, c;
        z = ent(1'b0, 6'd0, 32'd0, 5'd0);
        t = ent(1'b1, 6'd12, 32'hDEADBEEF, 5'd3);
        c = ent(1'b0, 6'd7, 32'h0000_0011, 5'd9);

        // lq_vld, lq, ms_vld, ms, flush | cmp, we, out, lq_rdy, ms_rdy, cnt
        vecs.push_back(mk(0, z,       0, z,       0, 0, 0, z,       1, 1, 16'd0));
        vecs.push_back(mk(1, t,       0, z,       0, 1, 1, t,       1, 1, 16'd0));
        vecs.push_back(mk(0, z,       0, z,       0, 0, 0, t,       1, 1, 16'd0));
        vecs.push_back(mk(0, z,       1, c,       0, 1, 0, c,       1, 1, 16'd0));
        vecs.push_back(mk(1, lqe(1),  1, mse(2),  0, 1, 1, lqe(1),  1, 1, 16'd1));
        vecs.push_back(mk(0, z,       0, z,       0, 1, 1, mse(2),  1, 1, 16'd1));
        vecs.push_back(mk(0, z,       0, z,       0, 0, 0, mse(2),  1, 1, 16'd1));
        vecs.push_back(mk(1, lqe(3),  1, mse(4),  0, 1, 1, lqe(3),  1, 1, 16'd2));
        vecs.push_back(mk(1, lqe(5),  1, mse(6),  0, 1, 1, mse(4),  1, 1, 16'd3));
        vecs.push_back(mk(1, lqe(7),  1, mse(8),  0, 1, 1, lqe(5),  1, 0, 16'd4));
        vecs.push_back(mk(1, lqe(9),  1, mse(10), 0, 1, 1, mse(6),  0, 1, 16'd5));
        vecs.push_back(mk(0, z,       0, z,       0, 1, 1, lqe(7),  1, 1, 16'd6));
        vecs.push_back(mk(0, z,       0, z,       0, 1, 1, mse(8),  1, 1, 16'd7));
        vecs.push_back(mk(0, z,       0, z,       0, 1, 1, lqe(9),  1, 1, 16'd7));
        vecs.push_back(mk(0, z,       0, z,       0, 0, 0, lqe(9),  1, 1, 16'd7));
        vecs.push_back(mk(1, lqe(11), 1, mse(12), 0, 1, 1, mse(12), 1, 1, 16'd8));
        vecs.push_back(mk(1, lqe(13), 1, mse(14), 0, 1, 1, lqe(11), 1, 1, 16'd9));
        vecs.push_back(mk(1, lqe(15), 1, mse(16), 0, 1, 1, mse(14), 0, 1, 16'd10));
        vecs.push_back(mk(1, lqe(17), 1, mse(18), 1, 0, 0, mse(14), 1, 1, 16'd10));
        vecs.push_back(mk(0, z,       0, z,       0, 0, 0, mse(14), 1, 1, 16'd10));
        vecs.push_back(mk(1, lqe(19), 1, mse(20), 0, 1, 1, lqe(19), 1, 1, 16'd11));
        vecs.push_back(mk(0, z,       0, z,       0, 1, 1, mse(20), 1, 1, 16'd11));
        vecs.push_back(mk(0, z,       0, z,       0, 0, 0, mse(20), 1, 1, 16'd11));

        drive(0, z, 0, z, 0);
        rst = 1'b1;
        repeat (3) step();
        chk_out("reset", 0, 0, z, 1, 1, 16'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].lv, vecs[i].le, vecs[i].mv, vecs[i].me, vecs[i].fl);
            step();
            chk_out($sformatf("row%0d", i), vecs[i].e_cmp, vecs[i].e_we, vecs[i].e_out,
                    vecs[i].e_lrdy, vecs[i].e_mrdy, vecs[i].e_cnt);
        end

        // Reset in the middle of a stream with both FIFOs holding work.
        drive(1, lqe(21), 1, mse(22), 0);
        step();
        drive(1, lqe(23), 1, mse(24), 0);
        step();
        rst = 1'b1;
        step();
        chk_out("midreset", 0, 0, z, 1, 1, 16'd0);
        rst = 1'b0;
        drive(0, z, 0, z, 0);
        step();
        chk_out("postreset", 0, 0, z, 1, 1, 16'd0);

        // Continuous contention: LQ wins the first conflict, counter saturates.
        drive(1, lqe(1), 1, mse(2), 0);
        step();
        chk("sat first rob", 32'(bus.cmp_rob_o), 32'd1);
        chk("sat first cnt", 32'(bus.conflict_cnt_o), 32'd1);
        step();
        chk("sat second rob", 32'(bus.cmp_rob_o), 32'd2);
        for (int k = 0; k < 65538; k++) step();
        chk("sat cnt", 32'(bus.conflict_cnt_o), 32'hFFFF);
        step();
        chk("sat hold", 32'(bus.conflict_cnt_o), 32'hFFFF);
        drive(0, z, 0, z, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
